bitcnt_arb: RTL
===============

// Module: bitcnt_arb
// PURPOSE
//  Round-robin arbiter and sequencer that shares one combinational bitcnt unit
//  (CLZ/CTZ/PCNT, 32/64-bit) among NREQ valid/ready requesters.
//  Registers the winning operand and function, drives the bitcnt unit for one
//  EXEC cycle, then captures the count and holds it on a response port until
//  the consumer takes it. The bitcnt unit is external; its pins are ports here.
// PARAMETERS
//  NREQ  2  number of requesters, 2..8
//  IDW   1  requester-id width, $clog2(NREQ) (minimum 1)
// PORTS
//  clock         in   1         single clock; all logic on its rising edge
//  reset         in   1         synchronous, active-high
//  req_valid     in   NREQ      per-requester request valid
//  req_ready     out  NREQ      per-requester accept; one-hot or zero
//  req_data      in   NREQ*64   operand; requester i uses [64*i+63:64*i]
//  req_func      in   NREQ*3    function code; requester i uses [3*i+2:3*i]
//  bc_din_data   out  64        operand to the bitcnt unit
//  bc_din_func   out  3         function to the bitcnt unit
//  bc_dout_data  in   64        bitcnt result, combinational from bc_din_*
//  rsp_valid     out  1         response valid
//  rsp_ready     in   1         response accept
//  rsp_data      out  64        count: value 0..64 in bits [6:0], bits [63:7] = 0
//  rsp_id        out  IDW       index of the requester that issued the op
//  rsp_err       out  1         1 = func was 3'b110 or 3'b111 (unused); rsp_data = 0
//  op_count      out  32        completed responses (rsp_valid & rsp_ready); wraps at 2^32
// BEHAVIOUR
//  - Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0,
//    rsp_err=0, op_count=0, bc_din_data=0, bc_din_func=0, req_ready=0.
//  - FSM states: IDLE, EXEC, RESP.
//    IDLE: accept_en=1. Any req_valid set -> grant and go to EXEC.
//    EXEC: exactly 1 cycle. Capture bc_dout_data into rsp_data and go to RESP.
//    RESP: rsp_valid=1; rsp_data/rsp_id/rsp_err are stable until taken.
//          If rsp_ready=0, stay in RESP.
//          If rsp_ready=1 and a new grant occurs, go to EXEC.
//          If rsp_ready=1 and no grant occurs, go to IDLE.
//  - accept_en = (state==IDLE) | (state==RESP & rsp_ready).
//    req_ready[g] = accept_en & grant[g]. req_ready may depend on req_valid and
//    on rsp_ready; req_valid must not depend on req_ready.
//  - Round-robin: search starts at index rr_ptr+1 (mod NREQ) and wraps; first
//    req_valid found wins. On accept, rr_ptr <= winner. A lone requester wins
//    on every accept.
//  - On accept: bc_din_data <= winner's data; rsp_id <= winner.
//    Func 0..5: bc_din_func <= winner's func.
//    Func 6/7: bc_din_func <= 3'b100 (a legal code, so the unit never sees an
//    unused code), err_q <= 1, and the captured result is forced to 0.
//  - bc_din_* stay constant from the accept edge until the next accept.
//  - Latency: accept at edge N, EXEC during cycle N+1, rsp_valid=1 from N+2.
//    Back-to-back throughput: one op per 2 cycles with rsp_ready held high.
//  - Result width: capture bc_dout_data[6:0]; rsp_data[63:7] is forced to 0.
//  - Requests are not queued. An unaccepted requester must hold valid, data and
//    func; the block never drops a held request. With NREQ requesters all
//    valid, each one is granted within NREQ accepts.
//  - Reset asserted mid-EXEC or mid-RESP: the in-flight op is discarded, no
//    response is produced, and all state returns to reset values on that edge.
//  - rsp_valid=1 & rsp_ready=1 on the same edge as reset: reset wins and
//    op_count is not incremented.
// TESTING
//  T1 single req0 data=64'h0000_0000_00F0_0000, func=000 (CLZ64):
//     rsp_valid 2 cycles after accept, rsp_data=40, rsp_id=0, rsp_err=0.
//  T2 req0 and req1 both valid from reset, 4 ops each, rsp_ready=1:
//     grants alternate 1,0,1,0,...; one response every 2 cycles; op_count=8.
//  T3 func=101 (PCNT32), data=64'hFFFF_FFFF_0000_000F -> rsp_data=4;
//     func=011 (CTZ32), data=64'h1_0000_0000 -> rsp_data=32.
//  T4 func=111 -> rsp_err=1, rsp_data=0, bc_din_func=100; next legal op has
//     rsp_err=0.
//  T5 rsp_ready=0 for 10 cycles in RESP: rsp_* stable, req_ready=0 throughout,
//     other requests wait; rsp_ready=1 -> one completion, op_count +1.
//  T6 reset pulse during EXEC: no rsp_valid afterwards, op_count=0, rr_ptr=0;
//     a held req1 is accepted on the first cycle after reset.

Source files
------------

// File: rtl/bitcnt_arb_if.sv
// Requester and response handshake bundle for bitcnt_arb.
// The master side is the requesters/consumer; the slave side is the arbiter.
interface bitcnt_arb_if #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*64-1:0] req_data;
  logic [NREQ*3-1:0]  req_func;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [63:0]        rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_err;

  modport master (
    output req_valid, req_data, req_func, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_data, req_func, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/bitcnt_arb.sv
// Round-robin arbiter that time-shares one external combinational bitcnt unit
// (CLZ/CTZ/PCNT) among NREQ requesters: accept -> one EXEC cycle -> held response.
module bitcnt_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic        clock,
  input  logic        reset,
  bitcnt_arb_if.slave bus,
  output logic [63:0] bc_din_data,
  output logic [2:0]  bc_din_func,
  input  logic [63:0] bc_dout_data,
  output logic [31:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic           accept_en;
  logic           accept;
  logic [63:0]    win_data;
  logic [2:0]     win_func;
  logic           win_bad;
  int             idx;
  logic           unused_dout_hi;

  // Only the 7-bit count is meaningful; the unit's upper bits are ignored.
  assign unused_dout_hi = ^bc_dout_data[63:7];

  // Search starts one past the last winner so every held request is reached
  // within NREQ accepts.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  assign win_data = bus.req_data[64*grant_idx +: 64];
  assign win_func = bus.req_func[3*grant_idx +: 3];
  assign win_bad  = (win_func[2:1] == 2'b11);

  always_comb begin
    state_d   = state_q;
    accept_en = 1'b0;
    case (state_q)
      IDLE: begin
        accept_en = 1'b1;
        if (grant_any) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          accept_en = 1'b1;
          state_d   = grant_any ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept        = accept_en & grant_any;
  assign bus.rsp_valid = (state_q == RESP);

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant_idx] = 1'b1;
  end

  // rsp_err is loaded at accept and therefore already describes the op in EXEC.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr       <= '0;
      bc_din_data  <= '0;
      bc_din_func  <= '0;
      bus.rsp_data <= '0;
      bus.rsp_id   <= '0;
      bus.rsp_err  <= 1'b0;
      op_count     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rr_ptr      <= grant_idx;
        bc_din_data <= win_data;
        bc_din_func <= win_bad ? 3'b100 : win_func;
        bus.rsp_id  <= grant_idx;
        bus.rsp_err <= win_bad;
      end
      if (state_q == EXEC)
        bus.rsp_data <= bus.rsp_err ? 64'd0 : {57'd0, bc_dout_data[6:0]};
      if (bus.rsp_valid && bus.rsp_ready)
        op_count <= op_count + 32'd1;
    end
  end

endmodule
